uart_rx_deframer: RTL and testbench
===================================

Name: uart_rx_deframer

Overview:
Serial receive front end that sits directly upstream of the UART control FSM. It samples the asynchronous rx line and deframes 8N1/8E1/8O1 characters. Each received byte is presented on dataOut with a one-cycle dataReady strobe, the same strobe/byte pair the control FSM consumes on its dataIn/dataReady inputs. Parity and framing errors are flagged alongside the byte.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, line bit rate
OVERSAMPLE, 16, sample ticks per bit (must be even, >= 8)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
rx  input  1  asynchronous serial line, idle high
parity_en  input  1  1 = a parity bit follows the 8 data bits
parity_odd  input  1  1 = odd parity, 0 = even; ignored when parity_en = 0
dataOut  output  8  last received byte, LSB first on the line
dataReady  output  1  one-cycle pulse, byte valid on dataOut
parity_error  output  1  valid only in the dataReady cycle
frame_error  output  1  valid only in the dataReady cycle; stop bit sampled 0
rx_busy  output  1  high from start-bit detection until return to IDLE

Behaviour:
- Reset (rst = 0 at a clk edge): dataOut = 8'h00, dataReady = 0, parity_error = 0, frame_error = 0, rx_busy = 0, state = IDLE, tick divider and counters cleared, synchroniser flops loaded with 1. Reset mid-character aborts the character and produces no strobe.
- Input sync: two-flop synchroniser on rx. All decisions use the second flop (rx_s), so there is 2 clk of latency from the pin.
- Tick generator: DIV = CLK_FREQ / (BAUD*OVERSAMPLE), truncated. If the result is 0, use 1. Counter wraps at DIV-1 and asserts a one-cycle tick. The counter is held at 0 in IDLE and restarts on the falling-edge detect, so sampling phase is aligned to the start bit.
- Sampling: within each bit, a sample counter s counts ticks 0..OVERSAMPLE-1. The bit value is the majority of rx_s at s = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
- FSM states:
  - IDLE: rx_busy = 0. A 1->0 transition on rx_s goes to START.
  - START: at the majority point, a 0 goes to DATA. A 1 (glitch) returns to IDLE with no strobe.
  - DATA: 8 bits, LSB first, shifted into a shift register. After bit 7 completes, go to PARITY if parity_en = 1, else go to STOP.
  - PARITY: the sampled bit is compared with the expected value, where expected = XOR(data) ^ parity_odd. A mismatch latches perr.
  - STOP: at the majority point, dataOut <= shift register and dataReady <= 1 for exactly one clk. parity_error <= perr. frame_error <= (stop sample == 0). If the stop sample is 1, go to IDLE. If it is 0, go to BREAK.
  - BREAK: wait until rx_s = 1, then go to IDLE. This prevents a held-low line from re-triggering.
- The strobe fires mid stop bit, not at its end. This allows back-to-back characters with no idle gap.
- parity_en and parity_odd are sampled at the START->DATA transition and held for the whole character. Changes mid-character have no effect until the next character.
- dataOut holds its value until the next strobe. There is no consumer handshake; a byte not taken in the strobe cycle is overwritten.
- parity_error and frame_error return to 0 the cycle after the strobe.

Test Plan:
- CLK_FREQ=1600000, BAUD=100000, OVERSAMPLE=16 (DIV=1, 16 clk/bit), 8N1, send 0xA5 -> exactly one dataReady pulse, dataOut=8'hA5, both error flags 0, the pulse lands 8-10 clk into the stop bit.
- Same config, parity_en=1, parity_odd=0, send 0x03 with parity bit 0 -> dataOut=8'h03, parity_error=0. Repeat with parity bit 1 -> dataOut=8'h03, parity_error=1.
- Send 0x3C with a stop bit of 0, then hold rx low for 40 clk, then release -> one strobe with frame_error=1 and dataOut=8'h3C. No second strobe while low. The next valid 0x55 is received normally.
- Glitch: rx low for 4 clk then high -> no strobe, rx_busy returns to 0 within 8 sample ticks.
- Back-to-back 0x00, 0xFF, 0x81 with no idle gap -> three strobes, 160 clk apart, with data in order.
- Pull rst low for one clk during bit 4 of 0x7E -> outputs take reset values, no strobe for that character. The next character, 0x12, is received correctly.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises rx, oversamples each bit with a 3-point majority vote
// and delivers 8N1/8E1/8O1 bytes with a one-cycle dataReady strobe plus parity/framing flags.
module uart_rx_deframer #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       parity_en,
  input  logic       parity_odd,
  output logic [7:0] dataOut,
  output logic       dataReady,
  output logic       parity_error,
  output logic       frame_error,
  output logic       rx_busy
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_LO     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI     = SW'(OVERSAMPLE / 2 + 1);

  // The falling-edge detect cycle is itself divider cycle 0, so the vote lands mid-bit.
  localparam logic [DW-1:0] DIV_FIRST = DW'((DIV == 1) ? 0 : 1);
  localparam logic [SW-1:0] S_FIRST   = SW'((DIV == 1) ? 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t          r_state;
  logic            r_rxMeta;
  logic            r_rxS;
  logic            r_rxSd;
  logic [DW-1:0]   r_divCnt;
  logic [SW-1:0]   r_sCnt;
  logic            r_samp0;
  logic            r_samp1;
  logic [7:0]      r_shift;
  logic [2:0]      r_bitCnt;
  logic            r_parEn;
  logic            r_parOdd;
  logic            r_perr;
  logic [7:0]      r_dataOut;
  logic            r_dataReady;
  logic            r_parityError;
  logic            r_frameError;
  logic            r_busy;

  logic w_fall;
  logic w_tick;
  logic w_vote;
  logic w_maj;

  assign w_fall = r_rxSd & ~r_rxS;
  assign w_tick = (r_state != ST_IDLE) && (r_divCnt == DIV_LAST);
  assign w_vote = w_tick && (r_sCnt == S_HI);
  assign w_maj  = (r_samp0 & r_samp1) | (r_samp0 & r_rxS) | (r_samp1 & r_rxS);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_rxMeta      <= 1'b1;
      r_rxS         <= 1'b1;
      r_rxSd        <= 1'b1;
      r_divCnt      <= '0;
      r_sCnt        <= '0;
      r_samp0       <= 1'b1;
      r_samp1       <= 1'b1;
      r_shift       <= 8'h00;
      r_bitCnt      <= 3'd0;
      r_parEn       <= 1'b0;
      r_parOdd      <= 1'b0;
      r_perr        <= 1'b0;
      r_dataOut     <= 8'h00;
      r_dataReady   <= 1'b0;
      r_parityError <= 1'b0;
      r_frameError  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_rxMeta      <= rx;
      r_rxS         <= r_rxMeta;
      r_rxSd        <= r_rxS;
      r_dataReady   <= 1'b0;
      r_parityError <= 1'b0;
      r_frameError  <= 1'b0;

      if (r_state != ST_IDLE) begin
        if (r_divCnt == DIV_LAST) begin
          r_divCnt <= '0;
        end else begin
          r_divCnt <= r_divCnt + 1'b1;
        end
        if (w_tick) begin
          r_sCnt <= (r_sCnt == S_LAST) ? '0 : r_sCnt + 1'b1;
          if (r_sCnt == S_LO) begin
            r_samp0 <= r_rxS;
          end
          if (r_sCnt == S_MID) begin
            r_samp1 <= r_rxS;
          end
        end
      end

      case (r_state)
        ST_IDLE: begin
          r_busy <= 1'b0;
          if (w_fall) begin
            r_state  <= ST_START;
            r_busy   <= 1'b1;
            r_divCnt <= DIV_FIRST;
            r_sCnt   <= S_FIRST;
          end else begin
            r_divCnt <= '0;
            r_sCnt   <= '0;
          end
        end

        ST_START: begin
          if (w_vote) begin
            if (!w_maj) begin
              r_state  <= ST_DATA;
              r_bitCnt <= 3'd0;
              r_parEn  <= parity_en;
              r_parOdd <= parity_odd;
              r_perr   <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end

        ST_DATA: begin
          if (w_vote) begin
            r_shift  <= {w_maj, r_shift[7:1]};
            r_bitCnt <= r_bitCnt + 3'd1;
            if (r_bitCnt == 3'd7) begin
              r_state <= r_parEn ? ST_PARITY : ST_STOP;
            end
          end
        end

        ST_PARITY: begin
          if (w_vote) begin
            if (w_maj != ((^r_shift) ^ r_parOdd)) begin
              r_perr <= 1'b1;
            end
            r_state <= ST_STOP;
          end
        end

        ST_STOP: begin
          // Strobe mid stop bit so a following start bit can be caught with no idle gap.
          if (w_vote) begin
            r_dataOut     <= r_shift;
            r_dataReady   <= 1'b1;
            r_parityError <= r_perr;
            r_frameError  <= ~w_maj;
            if (w_maj) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_BREAK;
            end
          end
        end

        ST_BREAK: begin
          if (r_rxS) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dataOut      = r_dataOut;
  assign dataReady    = r_dataReady;
  assign parity_error = r_parityError;
  assign frame_error  = r_frameError;
  assign rx_busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer at 16 clk per bit: frames are serialised on rx,
// expected bytes/flags are queued at send time and popped on each dataReady strobe.
module tb_uart_rx_deframer;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       parity_en;
  logic       parity_odd;
  logic [7:0] dataOut;
  logic       dataReady;
  logic       parity_error;
  logic       frame_error;
  logic       rx_busy;

  int   cyc = 0;
  int   vectorsApplied = 0;
  int   miscompares = 0;
  int   strobeCount = 0;
  int   stopDriveCyc = 0;
  int   strobeQ[$];
  exp_t sbQ[$];
  exp_t expItem;

  always #5 clk = ~clk;

  uart_rx_deframer #(
    .CLK_FREQ(1600000),
    .BAUD(100000),
    .OVERSAMPLE(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .parity_en(parity_en),
    .parity_odd(parity_odd),
    .dataOut(dataOut),
    .dataReady(dataReady),
    .parity_error(parity_error),
    .frame_error(frame_error),
    .rx_busy(rx_busy)
  );

  // Output monitor: every strobe is checked against the head of the scoreboard.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (dataReady === 1'b1) begin
      strobeCount++;
      strobeQ.push_back(cyc);
      vectorsApplied++;
      if (sbQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_strobe: got dataOut=%h, required no strobe", dataOut);
      end else begin
        expItem = sbQ.pop_front();
        if (dataOut !== expItem.data) begin
          miscompares++;
          $display("[TB] FAIL dataOut: got %h, required %h", dataOut, expItem.data);
        end
        vectorsApplied++;
        if (parity_error !== expItem.perr) begin
          miscompares++;
          $display("[TB] FAIL parity_error (byte %h): got %b, required %b", expItem.data, parity_error, expItem.perr);
        end
        vectorsApplied++;
        if (frame_error !== expItem.ferr) begin
          miscompares++;
          $display("[TB] FAIL frame_error (byte %h): got %b, required %b", expItem.data, frame_error, expItem.ferr);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [7:0] data, input logic parBit, input logic stopBit);
    exp_t e;
    e.data = data;
    e.perr = parity_en ? (parBit != ((^data) ^ parity_odd)) : 1'b0;
    e.ferr = ~stopBit;
    sbQ.push_back(e);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (16) @(negedge clk);
    end
    if (parity_en) begin
      rx = parBit;
      repeat (16) @(negedge clk);
    end
    stopDriveCyc = cyc;
    rx = stopBit;
    repeat (16) @(negedge clk);
  endtask

  task automatic idleLine(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic waitDrain(input string name);
    int budget;
    budget = 400;
    while (sbQ.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    vectorsApplied++;
    if (sbQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s_drain: got %0d bytes outstanding, required 0", name, sbQ.size());
      sbQ.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rx = 1'b1;
    parity_en = 1'b0;
    parity_odd = 1'b0;
    repeat (3) @(negedge clk);
    vectorsApplied++;
    if ({dataOut, dataReady, parity_error, frame_error, rx_busy} !== 12'h000) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h, required 000",
               {dataOut, dataReady, parity_error, frame_error, rx_busy});
    end
    rst = 1'b1;
    idleLine(10);
  endtask

  task automatic test_basic();
    int lat;
    strobeQ.delete();
    applyStimulus(8'hA5, 1'b0, 1'b1);
    idleLine(20);
    waitDrain("basic");
    vectorsApplied++;
    if (strobeQ.size() != 1) begin
      miscompares++;
      $display("[TB] FAIL basic_strobes: got %0d, required 1", strobeQ.size());
    end else begin
      // Edges from stop bit on the pin to the strobe, less the 2-flop synchroniser.
      lat = strobeQ[0] - stopDriveCyc - 2;
      vectorsApplied++;
      if (lat < 8 || lat > 10) begin
        miscompares++;
        $display("[TB] FAIL basic_latency: got %0d clk into stop bit, required 8..10", lat);
      end
    end
  endtask

  task automatic test_parity();
    parity_en = 1'b1;
    parity_odd = 1'b0;
    applyStimulus(8'h03, 1'b0, 1'b1);
    idleLine(10);
    applyStimulus(8'h03, 1'b1, 1'b1);
    idleLine(10);
    parity_odd = 1'b1;
    applyStimulus(8'h03, 1'b1, 1'b1);
    idleLine(10);
    applyStimulus(8'hC4, 1'b1, 1'b1);
    idleLine(10);
    waitDrain("parity");
    parity_en = 1'b0;
    parity_odd = 1'b0;
  endtask

  task automatic test_frame_error();
    int base;
    base = strobeCount;
    applyStimulus(8'h3C, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    vectorsApplied++;
    if (strobeCount - base != 1) begin
      miscompares++;
      $display("[TB] FAIL break_strobes: got %0d while low, required 1", strobeCount - base);
    end
    idleLine(20);
    applyStimulus(8'h55, 1'b0, 1'b1);
    idleLine(20);
    waitDrain("frame");
    vectorsApplied++;
    if (strobeCount - base != 2) begin
      miscompares++;
      $display("[TB] FAIL frame_total_strobes: got %0d, required 2", strobeCount - base);
    end
  endtask

  task automatic test_glitch();
    int base;
    int n;
    base = strobeCount;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    vectorsApplied++;
    if (rx_busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL glitch_busy_set: got %b, required 1", rx_busy);
    end
    rx = 1'b1;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (rx_busy === 1'b0) break;
    end
    vectorsApplied++;
    if (rx_busy !== 1'b0 || n > 8) begin
      miscompares++;
      $display("[TB] FAIL glitch_busy_clear: got busy=%b after %0d clk, required 0 within 8", rx_busy, n);
    end
    idleLine(40);
    vectorsApplied++;
    if (strobeCount != base) begin
      miscompares++;
      $display("[TB] FAIL glitch_strobes: got %0d, required 0", strobeCount - base);
    end
  endtask

  task automatic test_back_to_back();
    strobeQ.delete();
    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'hFF, 1'b0, 1'b1);
    applyStimulus(8'h81, 1'b0, 1'b1);
    idleLine(20);
    waitDrain("b2b");
    vectorsApplied++;
    if (strobeQ.size() != 3) begin
      miscompares++;
      $display("[TB] FAIL b2b_strobes: got %0d, required 3", strobeQ.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        vectorsApplied++;
        if (strobeQ[i] - strobeQ[i-1] != 160) begin
          miscompares++;
          $display("[TB] FAIL b2b_spacing%0d: got %0d clk, required 160", i, strobeQ[i] - strobeQ[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    int base;
    logic [7:0] abortByte;
    abortByte = 8'h7E;
    base = strobeCount;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = abortByte[i];
      repeat (16) @(negedge clk);
    end
    rx = abortByte[4];
    repeat (8) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectorsApplied++;
    if ({dataOut, dataReady, parity_error, frame_error, rx_busy} !== 12'h000) begin
      miscompares++;
      $display("[TB] FAIL abort_reset_outputs: got %h, required 000",
               {dataOut, dataReady, parity_error, frame_error, rx_busy});
    end
    @(negedge clk);
    rst = 1'b1;
    idleLine(60);
    vectorsApplied++;
    if (strobeCount != base) begin
      miscompares++;
      $display("[TB] FAIL abort_strobes: got %0d, required 0", strobeCount - base);
    end
    applyStimulus(8'h12, 1'b0, 1'b1);
    idleLine(20);
    waitDrain("after_abort");
  endtask

  initial begin
    rst = 1'b0;
    rx = 1'b1;
    parity_en = 1'b0;
    parity_odd = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_parity();
    test_frame_error();
    test_glitch();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
